mdu_seq: RTL and testbench

//   Iterative multiply/divide sequencer beside the EX-stage ALU of the five-stage pipeline.

---
 rtl/mdu_seq.sv | 179 +++++++++++++++++
 tb/tb_mdu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative multiply/divide sequencer owning the HI/LO registers
//
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   start   op request from EX, sampled on the clock edge
//   op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a       rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b       rt operand (multiplier / divisor)
//   abort   synchronous cancel of the in-flight op; wins over a same-edge start
//   busy    high while a mul/div is in progress (CALC or FIX)
//   done    one-cycle pulse after HI/LO were written by a mul/div
//   hi, lo  architectural HI/LO registers
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               neg_res_q;   // product / quotient must be negated
    logic               neg_rem_q;   // remainder takes the dividend's sign
    logic               div_zero_q;
    logic [WIDTH-1:0]   op_a_q;      // multiplicand magnitude
    logic [WIDTH-1:0]   op_b_q;      // divisor magnitude
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   low half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // Operand conditioning at issue. Negating 0x80000000 leaves the same
    // bit pattern, which read as unsigned is the correct magnitude.
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign op_signed = ~op[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right; the
    // carry out of the add becomes the new top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring-divide step on a WIDTH+1 bit trial remainder. The result of
    // a successful subtract is always below the divisor, so WIDTH bits hold it.
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial    = {rem_q, acc_q[WIDTH-1]};
    assign div_ge       = div_trial >= {1'b0, op_b_q};
    assign div_rem_next = div_ge ? (div_trial[WIDTH-1:0] - op_b_q) : div_trial[WIDTH-1:0];
    assign div_next     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};

    // Sign fix-up applied on the FIX edge. A zero divisor yields an
    // all-ones quotient and a remainder equal to the original dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = div_zero_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        case (op)
                            3'b100: hi_q <= a;
                            3'b101: lo_q <= a;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                op_a_q     <= a_mag;
                                op_b_q     <= b_mag;
                                is_div_q   <= op[1];
                                neg_res_q  <= a_neg ^ b_neg;
                                neg_rem_q  <= a_neg;
                                div_zero_q <= (b == '0);
                                rem_q      <= '0;
                                acc_q      <= op[1] ? {{WIDTH{1'b0}}, a_mag}
                                                    : {{WIDTH{1'b0}}, b_mag};
                                cnt_q      <= '0;
                                state_q    <= S_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            acc_q <= div_next;
                            rem_q <= div_rem_next;
                        end else begin
                            acc_q <= mul_next;
                        end
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!abort) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq with directed vectors
module tb_mdu_seq;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clock = ~clock;

    mdu_seq #(.WIDTH(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clock) begin
        exp_t e;
        if (resetn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending result");
            end else begin
                e = sb.pop_front();
                check({e.tag, "_hi"}, hi, e.hi);
                check({e.tag, "_lo"}, lo, e.lo);
                check({e.tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic expect_result(input string tag, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.tag = tag;
        e.hi  = eh;
        e.lo  = el;
        sb.push_back(e);
    endtask

    // Called on a negedge; start is seen by exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts negedges from the first one after the start edge up to and
    // including the one showing done.
    task automatic wait_done(input string tag, output int busy_n, output int lat);
        busy_n = 0;
        lat    = 0;
        for (int i = 0; i < 60; i++) begin
            lat++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) return;
            @(negedge clock);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got no done in 60 cycles required done", tag);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int bn;
        int lt;
        expect_result(tag, eh, el);
        issue(o, x, y);
        wait_done(tag, bn, lt);
        check({tag, "_latency"}, lt, 32'd34);
    endtask

    initial begin
        int bn;
        int lt;
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        op     = 3'b000;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clock);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        expect_result("multu_max", 32'hFFFFFFFE, 32'h00000001);
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max", bn, lt);
        check("multu_busy_cycles", bn, 32'd33);
        check("multu_latency", lt, 32'd34);

        run("mult_neg",       3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mult_minmin",    3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div_neg_dvd",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_neg_dvs",    3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run("div_overflow",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("divu_by_zero",   3'b011, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
        run("div_by_zero",    3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        // Second op issued in the done cycle of the first.
        run("b2b_first",      3'b001, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);
        run("b2b_second",     3'b001, 32'd6,        32'd7,        32'h00000000, 32'h0000002A);
        repeat (2) @(negedge clock);

        issue(3'b100, 32'hA5A5A5A5, 32'h0);
        check("mthi_hi", hi, 32'hA5A5A5A5);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_done", {31'b0, done}, 32'd0);
        issue(3'b101, 32'h5A5A5A5A, 32'h0);
        check("mtlo_lo", lo, 32'h5A5A5A5A);
        check("mtlo_hi_kept", hi, 32'hA5A5A5A5);

        // MTLO/MTHI while busy must be ignored.
        expect_result("divu_mt_busy", 32'h00000002, 32'h0000000E);
        issue(3'b011, 32'd100, 32'd7);
        repeat (4) @(negedge clock);
        issue(3'b101, 32'hDEADBEEF, 32'h0);
        issue(3'b100, 32'hCAFEF00D, 32'h0);
        check("mt_busy_lo_kept", lo, 32'h5A5A5A5A);
        wait_done("divu_mt_busy", bn, lt);
        @(negedge clock);

        // Abort in IDLE blocks a same-edge MTHI.
        abort = 1'b1;
        issue(3'b100, 32'h12345678, 32'h0);
        abort = 1'b0;
        check("idle_abort_hi", hi, 32'h00000002);

        // Abort mid-CALC: no done, hi/lo keep their values.
        issue(3'b011, 32'd1000, 32'd3);
        repeat (8) @(negedge clock);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy_after", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clock);
        check("abort_hi_kept", hi, 32'h00000002);
        check("abort_lo_kept", lo, 32'h0000000E);

        // Reset mid-CALC clears everything.
        issue(3'b000, 32'h00001234, 32'h00005678);
        repeat (5) @(negedge clock);
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        resetn = 1'b1;
        repeat (40) @(negedge clock);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
